// File: rtl/btn_pkg.sv
// Shared constants, state encoding and width helper for the button conditioning blocks.
package btn_pkg;

  localparam int CLK_HZ        = 12_000_000;
  localparam int DEBOUNCE_10MS = CLK_HZ / 100;
  localparam int LONG_1S       = CLK_HZ;
  localparam int REPEAT_250MS  = CLK_HZ / 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_DB   = 3'd1,
    ST_PRESSED    = 3'd2,
    ST_LONG_HELD  = 3'd3,
    ST_RELEASE_DB = 3'd4
  } btn_state_t;

  // Counter width able to hold limit-1, never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/button_input_conditioner_if.sv
// Button pin plus conditioned outputs; slave is the conditioner, master is the consumer/pin side.
interface button_input_conditioner_if #(
  parameter int CNT_W = 8
);

  logic             BTN_IN;
  logic             BTN_LEVEL;
  logic             PRESS_PULSE;
  logic             RELEASE_PULSE;
  logic             LONG_PULSE;
  logic [CNT_W-1:0] PRESS_COUNT;

  modport master (
    output BTN_IN,
    input  BTN_LEVEL, PRESS_PULSE, RELEASE_PULSE, LONG_PULSE, PRESS_COUNT
  );

  modport slave (
    input  BTN_IN,
    output BTN_LEVEL, PRESS_PULSE, RELEASE_PULSE, LONG_PULSE, PRESS_COUNT
  );

endinterface

// File: rtl/input_synchronizer.sv
// Two-flop synchroniser for asynchronous board inputs; both flops reset to RESET_VAL.
module input_synchronizer #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic async_in,
  output logic sync_out
);

  localparam int STAGES = 2;

  logic [STAGES-1:0] sync_reg;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic d;
    if (gi == 0) begin : g_first
      assign d = async_in;
    end else begin : g_next
      assign d = sync_reg[gi-1];
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) sync_reg[gi] <= RESET_VAL;
      else     sync_reg[gi] <= d;
    end
  end

  assign sync_out = sync_reg[STAGES-1];

endmodule

// File: rtl/button_input_conditioner.sv
// Synchronises and debounces one raw button into a clean level, press/release/long pulses and a press count.
// Optional macro BTN_REPEAT_EN: PRESS_PULSE auto-repeats every REPEAT_CYCLES while a long press is held.
module button_input_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_10MS,
  parameter int LONG_PRESS_CYCLES = LONG_1S,
  parameter int ACTIVE_LOW        = 1,
  parameter int CNT_W             = 8,
  parameter int REPEAT_CYCLES     = REPEAT_250MS
) (
  input logic CLK,
  input logic RST,
  button_input_conditioner_if.slave btn
);

  localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  localparam logic [2:0] IDLE       = ST_IDLE;
  localparam logic [2:0] PRESS_DB   = ST_PRESS_DB;
  localparam logic [2:0] PRESSED    = ST_PRESSED;
  localparam logic [2:0] LONG_HELD  = ST_LONG_HELD;
  localparam logic [2:0] RELEASE_DB = ST_RELEASE_DB;

  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("button_input_conditioner: illegal cycle parameters");
  end

  logic              sync_raw;
  logic              p;
  logic [2:0]        state_reg;
  logic [DB_W-1:0]   db_cnt_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              from_long_reg;
  logic              level_reg;
  logic              press_reg;
  logic              release_reg;
  logic              long_reg;
  logic [CNT_W-1:0]  count_reg;

  input_synchronizer #(
    .RESET_VAL (ACTIVE_LOW != 0)
  ) u_sync (
    .CLK      (CLK),
    .RST      (RST),
    .async_in (btn.BTN_IN),
    .sync_out (sync_raw)
  );

  // Everything downstream works on active-high "pressed".
  assign p = (ACTIVE_LOW != 0) ? ~sync_raw : sync_raw;

`ifdef BTN_REPEAT_EN
  localparam int REP_W = cnt_width(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt_reg;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      db_cnt_reg    <= '0;
      hold_cnt_reg  <= '0;
      from_long_reg <= 1'b0;
      level_reg     <= 1'b0;
      press_reg     <= 1'b0;
      release_reg   <= 1'b0;
      long_reg      <= 1'b0;
      count_reg     <= '0;
`ifdef BTN_REPEAT_EN
      rep_cnt_reg   <= '0;
`endif
    end else begin
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      long_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (p) begin
            state_reg  <= PRESS_DB;
            db_cnt_reg <= '0;
          end
        end
        PRESS_DB: begin
          if (!p) begin
            state_reg <= IDLE;
          end else if (db_cnt_reg == DB_LAST) begin
            state_reg    <= PRESSED;
            level_reg    <= 1'b1;
            press_reg    <= 1'b1;
            count_reg    <= count_reg + 1'b1;
            hold_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end
        PRESSED: begin
          if (!p) begin
            state_reg     <= RELEASE_DB;
            db_cnt_reg    <= '0;
            from_long_reg <= 1'b0;
          end else if (hold_cnt_reg == HOLD_LAST) begin
            state_reg <= LONG_HELD;
            long_reg  <= 1'b1;
`ifdef BTN_REPEAT_EN
            rep_cnt_reg <= '0;
`endif
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        LONG_HELD: begin
          if (!p) begin
            state_reg     <= RELEASE_DB;
            db_cnt_reg    <= '0;
            from_long_reg <= 1'b1;
`ifdef BTN_REPEAT_EN
            rep_cnt_reg   <= '0;
          end else if (rep_cnt_reg == REP_LAST) begin
            rep_cnt_reg <= '0;
            press_reg   <= 1'b1;
            count_reg   <= count_reg + 1'b1;
          end else begin
            rep_cnt_reg <= rep_cnt_reg + 1'b1;
`endif
          end
        end
        RELEASE_DB: begin
          // A bounce back to pressed resumes the held state; hold counter is untouched.
          if (p) begin
            state_reg <= from_long_reg ? LONG_HELD : PRESSED;
          end else if (db_cnt_reg == DB_LAST) begin
            state_reg   <= IDLE;
            level_reg   <= 1'b0;
            release_reg <= 1'b1;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign btn.BTN_LEVEL     = level_reg;
  assign btn.PRESS_PULSE   = press_reg;
  assign btn.RELEASE_PULSE = release_reg;
  assign btn.LONG_PULSE    = long_reg;
  assign btn.PRESS_COUNT   = count_reg;

endmodule

// File: doc/button_input_conditioner.md
Name: button_input_conditioner

Overview:
- Input-side counterpart to the LED pattern outputs on the 12 MHz iCEstick design.
- Takes one raw, bouncy pushbutton or header pin and synchronises it to CLK, then debounces it.
- Produces a clean level, single-cycle press/release/long-press pulses and a wrapping press counter.
- These outputs drive LED pattern selection and mode stepping in the top level.

Parameters:
- DEBOUNCE_CYCLES, 120_000, consecutive stable cycles required to accept a new level (10 ms at 12 MHz); legal values ≥ 2.
- LONG_PRESS_CYCLES, 12_000_000, cycles the debounced press must last before LONG_PULSE (1 s); must be > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = reads 1 when pressed.
- CNT_W, 8, width of PRESS_COUNT.
- REPEAT_CYCLES, 3_000_000, auto-repeat period (250 ms); used only with BTN_REPEAT_EN.

Ports:
- CLK  input  1  12 MHz system clock.
- RST  input  1  reset, asynchronous, active-high.
- BTN_IN  input  1  raw asynchronous button pin.
- BTN_LEVEL  output  1  debounced pressed state, active-high.
- PRESS_PULSE  output  1  one-cycle pulse on accepted press.
- RELEASE_PULSE  output  1  one-cycle pulse on accepted release.
- LONG_PULSE  output  1  one-cycle pulse when the press reaches LONG_PRESS_CYCLES.
- PRESS_COUNT  output  CNT_W  number of accepted presses, modulo 2^CNT_W.

Behaviour:
- Interface: single clock CLK; reset RST is asynchronous and active-high. All state and outputs reset immediately on RST assertion.
- Reset values:
  - All outputs 0; FSM in IDLE.
  - Debounce and hold counters 0.
  - Synchroniser flops at the *inactive* pin level (1 if ACTIVE_LOW, else 0).
- Polarity: the synchronised value is normalised to active-high "pressed" (p) immediately after the 2-flop synchroniser.
- FSM states: IDLE, PRESS_DB, PRESSED, LONG_HELD, RELEASE_DB.
- IDLE:
  - p=1 → PRESS_DB; debounce counter cleared.
- PRESS_DB:
  - Counter increments each cycle p=1.
  - p=0 at any point → back to IDLE. Bounce is discarded and no pulse is emitted.
  - Counter reaches DEBOUNCE_CYCLES-1 with p=1 → PRESSED. BTN_LEVEL←1 and PRESS_PULSE=1 for exactly one cycle; PRESS_COUNT increments on the same edge.
- PRESSED:
  - Hold counter counts from 0.
  - p=0 → RELEASE_DB.
  - Hold counter reaches LONG_PRESS_CYCLES-1 → LONG_HELD with LONG_PULSE=1 for one cycle.
  - The hold counter includes only post-debounce cycles.
- LONG_HELD:
  - p=0 → RELEASE_DB.
  - LONG_PULSE never repeats within one press.
- RELEASE_DB:
  - p must stay 0 for DEBOUNCE_CYCLES cycles. Then go to IDLE with BTN_LEVEL←0 and RELEASE_PULSE=1 for one cycle.
  - p=1 before that → return to the state RELEASE_DB was entered from (PRESSED or LONG_HELD). The hold counter keeps its value, with no extra press and no pulse.
- Latency: a clean raw edge gives its pulse exactly 2 + DEBOUNCE_CYCLES rising edges after the first CLK edge that samples the new level.
- Pulse rules:
  - At most one of PRESS_PULSE, RELEASE_PULSE or LONG_PULSE is high in any cycle.
  - All outputs are registered, so none is combinational from BTN_IN.
- PRESS_COUNT wraps from 2^CNT_W-1 to 0 with no saturation or flag.
- Reset mid-press: on RST release with the button still held, the block behaves as a fresh press. After debounce it emits PRESS_PULSE and counts one press.
- Counter widths: each is $clog2 of its limit, with the comparison made at full width. There is no truncation for the 12 M default.

Optional Feature:
- BTN_REPEAT_EN defined: in LONG_HELD, PRESS_PULSE re-fires every REPEAT_CYCLES cycles.
  - The first repeat comes REPEAT_CYCLES after LONG_PULSE.
  - Each repeat increments PRESS_COUNT.
  - The repeat counter clears on leaving LONG_HELD or entering RELEASE_DB.
- BTN_REPEAT_EN undefined: no repeat logic or counter is synthesised, and REPEAT_CYCLES is ignored.

Decomposition:
- Package btn_pkg:
  - State enum typedef btn_state_t.
  - Constants CLK_HZ=12_000_000, DEBOUNCE_10MS, LONG_1S and REPEAT_250MS, used as parameter defaults.
- Sub-module input_synchronizer:
  - 2-flop synchroniser with a parameterised reset level (RESET_VAL).
  - Reused for the other board inputs.

Test Plan (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, CNT_W=4, ACTIVE_LOW=1, REPEAT_CYCLES=8):
- Clean press: BTN_IN 1→0 and held 30 cycles → PRESS_PULSE 6 edges after the change and PRESS_COUNT=1. LONG_PULSE follows 20 cycles after PRESS_PULSE, with exactly one LONG_PULSE.
- Bounce: BTN_IN pattern 0,1,0,1 one cycle each, then 1 → no pulses, PRESS_COUNT=0 and BTN_LEVEL stays 0.
- Release bounce: while pressed, a 2-cycle high glitch → no RELEASE_PULSE and no extra count. A true release held 10 cycles → one RELEASE_PULSE and BTN_LEVEL=0.
- Wrap: 17 clean short presses → PRESS_COUNT=1, with no LONG_PULSE ever.
- Async reset: RST asserted mid-press (between clock edges) → all outputs 0 at once. Button still held after release → PRESS_PULSE 6 cycles later and PRESS_COUNT=1.
- BTN_REPEAT_EN: hold 60 cycles → PRESS_PULSE at +0, LONG_PULSE at +20, repeats at +28, +36, +44 and +52. PRESS_COUNT=5 before release.
